serial_sample_receiver: RTL and testbench
=========================================

Name: serial_sample_receiver

Overview:
- Receive end of the 12-bit sample serial link: accepts frames on SCL/SS/MOSI from a sample transmitter and rebuilds each 12-bit sample.
- Sits between the serial pins and downstream logic such as a DAC driver or a check/compare unit.
- Buffers received samples in a FIFO and presents them on a valid/ready handshake, with sticky overflow and framing-error flags.

Parameters:
- DEPTH, 16, number of FIFO entries; power of 2, minimum 2.
- AW, 4, FIFO address width; equals log2(DEPTH).

Ports:
- clk  input  1  system clock, 50 MHz
- rst  input  1  asynchronous, active-high reset
- SCL  input  1  serial clock from transmitter, 100 kHz nominal, asynchronous to clk
- SS  input  1  frame select, active low, asynchronous to clk
- MOSI  input  1  serial data; sampled on SCL rising edge, MSB first
- sample_ready  input  1  downstream accepts sample_data this cycle
- sample_data  output  12  oldest buffered sample
- sample_valid  output  1  sample_data holds a valid sample
- fill_level  output  AW+1  number of samples held, 0..DEPTH
- overflow  output  1  sticky: a complete frame was dropped because the FIFO was full
- frame_err  output  1  sticky: SS deasserted after a bit count other than 12
- clr_flags  input  1  synchronous clear of overflow and frame_err

Behaviour:
- Reset (rst=1, asynchronous) clears:
  - synchronizers (SCL and SS synchronizer flops reset to 1, MOSI flops to 0), shift register, bit counter, FIFO pointers
  - sample_valid=0, sample_data=0, fill_level=0, overflow=0, frame_err=0
- Reset mid-frame discards the partial frame. After release, the receiver waits for a fresh SS falling edge.
- Synchronization:
  - SCL, SS and MOSI each pass through 2 flops, then 1 history flop for edge detection.
  - All logic uses the synchronized values only.
- States: IDLE, SHIFT, DONE.
  - IDLE: on synced SS falling edge, clear the bit counter and shift register, go to SHIFT.
  - SHIFT: on each synced SCL rising edge while SS is low, shift_reg = {shift_reg[10:0], MOSI_sync} and increment bit_cnt, saturating at 13.
  - SHIFT: on synced SS rising edge, go to DONE.
  - DONE (1 cycle):
    - bit_cnt==12: push shift_reg, or drop it and set overflow if full.
    - bit_cnt!=12: set frame_err and push nothing.
    - Go to IDLE.
- Edges outside a frame: SCL edges while SS is high are ignored. An SS rising edge in IDLE is ignored.
- FIFO:
  - First-word fall-through: sample_valid = (fill_level != 0); sample_data = mem[rd_ptr].
  - Pop when sample_valid && sample_ready. The next entry appears the following cycle.
  - Push and pop in the same cycle: both take effect and fill_level is unchanged. When full, a simultaneous pop frees the slot, so the push succeeds and overflow is not set.
  - Pointers are AW bits and wrap modulo DEPTH. fill_level is a separate counter.
- Latency: sample_valid rises 5 clk cycles after SS rises at the pin, given an empty FIFO.
  - 2 synchronizer flops + 1 edge-detect cycle + DONE cycle + 1 cycle for FIFO write to become visible.
- Flags:
  - overflow and frame_err are sticky until clr_flags=1 (synchronous) or rst.
  - If clr_flags and a set event occur in the same cycle, set wins.
- Timing requirement: SCL high and low phases must each last at least 3 clk periods. Faster SCL is out of scope.

Test Plan:
- Single frame: SS low, send 0xA5C MSB first over 12 SCL pulses at 100 kHz, SS high -> sample_valid=1 exactly 5 clk after SS rises, sample_data=0xA5C, fill_level=1. Pulse sample_ready -> fill_level=0, sample_valid=0.
- Ordering and wrap: with sample_ready=0, send 0x001..0x010 (16 frames) -> fill_level=16, overflow=0. Drain -> values come out 0x001..0x010 in order. Send 20 more frames while draining -> all received correctly across pointer wrap.
- Overflow: FIFO full (16 entries), send 0xFFF -> overflow=1, fill_level=16, 0xFFF absent. Pop once while a 17th frame's DONE cycle coincides -> push succeeds, fill_level stays 16.
- Framing error: frame with 11 bits, then one with 13 bits -> frame_err=1, fill_level=0. Pulse clr_flags -> frame_err=0. Next 12-bit 0x3C3 frame -> received correctly.
- Reset mid-frame: assert rst after 6 bits of 0x800 -> all outputs 0. Release and send full 0x7FF frame -> sample_data=0x7FF, frame_err=0.
- Idle noise: 20 SCL pulses with SS high -> no state change, fill_level=0, frame_err=0.

Source files
------------

// File: rtl/serial_sample_receiver.sv
// Receive end of the 12-bit sample serial link: synchronizes SCL/SS/MOSI, rebuilds each
// sample and buffers it in a first-word fall-through FIFO with sticky error flags.
module serial_sample_receiver #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          SCL,
    input  logic          SS,
    input  logic          MOSI,
    input  logic          sample_ready,
    output logic [11:0]   sample_data,
    output logic          sample_valid,
    output logic [AW:0]   fill_level,
    output logic          overflow,
    output logic          frame_err,
    input  logic          clr_flags
);

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    localparam logic [AW:0] FullLevel = (AW + 1)'(DEPTH);

    logic [1:0] scl_sync, ss_sync, mosi_sync;
    logic       scl_hist, ss_hist, mosi_hist;
    logic       scl_rise, ss_fall, ss_rise;

    state_e      state_q, state_d;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic [11:0] shift_q, shift_d;
    logic        push_req, frame_bad;

    logic [11:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   fill_q;
    logic          overflow_q, frame_err_q;
    logic          full, pop, push, ovf_set;

    // Edge pulses are registered so they line up with the history copy of MOSI and SS.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_sync  <= 2'b11;
            ss_sync   <= 2'b11;
            mosi_sync <= 2'b00;
            scl_hist  <= 1'b1;
            ss_hist   <= 1'b1;
            mosi_hist <= 1'b0;
            scl_rise  <= 1'b0;
            ss_fall   <= 1'b0;
            ss_rise   <= 1'b0;
        end else begin
            scl_sync  <= {scl_sync[0], SCL};
            ss_sync   <= {ss_sync[0], SS};
            mosi_sync <= {mosi_sync[0], MOSI};
            scl_hist  <= scl_sync[1];
            ss_hist   <= ss_sync[1];
            mosi_hist <= mosi_sync[1];
            scl_rise  <= scl_sync[1] & ~scl_hist;
            ss_fall   <= ~ss_sync[1] & ss_hist;
            ss_rise   <= ss_sync[1] & ~ss_hist;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            bit_cnt_q <= 4'd0;
            shift_q   <= 12'd0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        push_req  = 1'b0;
        frame_bad = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (ss_fall) begin
                    bit_cnt_d = 4'd0;
                    shift_d   = 12'd0;
                    state_d   = StShift;
                end
            end
            StShift: begin
                if (ss_rise) begin
                    state_d = StDone;
                end else if (scl_rise && !ss_hist) begin
                    shift_d = {shift_q[10:0], mosi_hist};
                    // Saturate at 13 so any overlong frame still reads as bad.
                    if (bit_cnt_q != 4'd13) begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
            end
            StDone: begin
                if (bit_cnt_q == 4'd12) begin
                    push_req = 1'b1;
                end else begin
                    frame_bad = 1'b1;
                end
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign full    = (fill_q == FullLevel);
    assign pop     = sample_valid & sample_ready;
    // A same-cycle pop frees the slot, so a push into a full FIFO still lands.
    assign push    = push_req & (~full | pop);
    assign ovf_set = push_req & full & ~pop;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= shift_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            fill_q      <= '0;
            overflow_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            if (push && !pop) begin
                fill_q <= fill_q + (AW + 1)'(1);
            end else if (pop && !push) begin
                fill_q <= fill_q - (AW + 1)'(1);
            end
            if (ovf_set) begin
                overflow_q <= 1'b1;
            end else if (clr_flags) begin
                overflow_q <= 1'b0;
            end
            if (frame_bad) begin
                frame_err_q <= 1'b1;
            end else if (clr_flags) begin
                frame_err_q <= 1'b0;
            end
        end
    end

    assign sample_valid = (fill_q != '0);
    assign sample_data  = sample_valid ? mem[rd_ptr_q] : 12'd0;
    assign fill_level   = fill_q;
    assign overflow     = overflow_q;
    assign frame_err    = frame_err_q;

endmodule

// File: tb/tb_serial_sample_receiver.sv
// Scoreboard bench for serial_sample_receiver: directed frames queue expected samples,
// a monitor pops and compares every accepted output sample.
module tb_serial_sample_receiver;

    logic        clk = 1'b0;
    logic        rst;
    logic        SCL, SS, MOSI;
    logic        sample_ready, clr_flags;
    logic [11:0] sample_data;
    logic        sample_valid;
    logic [4:0]  fill_level;
    logic        overflow, frame_err;

    int checks = 0;
    int errors = 0;
    logic [11:0] exp_q[$];
    logic [11:0] mon_exp;

    serial_sample_receiver #(.DEPTH(16), .AW(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .SCL          (SCL),
        .SS           (SS),
        .MOSI         (MOSI),
        .sample_ready (sample_ready),
        .sample_data  (sample_data),
        .sample_valid (sample_valid),
        .fill_level   (fill_level),
        .overflow     (overflow),
        .frame_err    (frame_err),
        .clr_flags    (clr_flags)
    );

    always #10 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Leaves SS low after the last bit so callers control the frame end.
    task automatic frame_bits(input logic [15:0] val, input int nbits, input int half);
        SS = 1'b0;
        wait_clk(half);
        for (int i = nbits - 1; i >= 0; i--) begin
            MOSI = val[i];
            wait_clk(half);
            SCL = 1'b1;
            wait_clk(half);
            SCL = 1'b0;
        end
        wait_clk(half);
    endtask

    task automatic send_frame(input logic [15:0] val, input int nbits, input int half);
        frame_bits(val, nbits, half);
        SS = 1'b1;
        wait_clk(10);
    endtask

    always @(negedge clk) begin
        if (!rst && sample_valid && sample_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_sample: got %03h, required none", sample_data);
            end else begin
                mon_exp = exp_q.pop_front();
                if (sample_data !== mon_exp) begin
                    errors++;
                    $display("FAIL sample_data: got %03h, required %03h", sample_data, mon_exp);
                end
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL timeout: simulation did not finish, required finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; SCL = 1'b0; SS = 1'b1; MOSI = 1'b0;
        sample_ready = 1'b0; clr_flags = 1'b0;
        wait_clk(3);
        check("reset_valid", sample_valid, 0);
        check("reset_data", sample_data, 0);
        check("reset_fill", fill_level, 0);
        check("reset_flags", {overflow, frame_err}, 0);
        rst = 1'b0;
        wait_clk(5);

        // Single frame at 100 kHz with latency measurement.
        exp_q.push_back(12'hA5C);
        frame_bits(16'h0A5C, 12, 250);
        SS = 1'b1;
        wait_clk(4);
        check("latency_not_early", sample_valid, 0);
        wait_clk(1);
        check("latency_valid", sample_valid, 1);
        check("single_data", sample_data, 12'hA5C);
        check("single_fill", fill_level, 1);
        sample_ready = 1'b1;
        wait_clk(1);
        sample_ready = 1'b0;
        check("single_fill_after_pop", fill_level, 0);
        check("single_valid_after_pop", sample_valid, 0);

        // Fill to capacity, then overflow.
        for (int v = 1; v <= 16; v++) begin
            exp_q.push_back(12'(v));
            send_frame(16'(v), 12, 8);
        end
        check("full_fill", fill_level, 16);
        check("full_no_overflow", overflow, 0);
        send_frame(16'h0FFF, 12, 8);
        check("overflow_set", overflow, 1);
        check("overflow_fill", fill_level, 16);
        clr_flags = 1'b1;
        wait_clk(1);
        clr_flags = 1'b0;
        check("overflow_cleared", overflow, 0);

        // Pop coinciding with the DONE cycle of a frame into a full FIFO.
        exp_q.push_back(12'h011);
        frame_bits(16'h0011, 12, 8);
        SS = 1'b1;
        wait_clk(4);
        sample_ready = 1'b1;
        wait_clk(1);
        sample_ready = 1'b0;
        wait_clk(5);
        check("coincide_fill", fill_level, 16);
        check("coincide_no_overflow", overflow, 0);

        sample_ready = 1'b1;
        wait_clk(40);
        sample_ready = 1'b0;
        check("drain_fill", fill_level, 0);
        check("drain_queue_empty", exp_q.size(), 0);

        // Continuous draining across pointer wrap.
        sample_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            exp_q.push_back(12'h100 + 12'(i * 7));
            send_frame(16'h0100 + 16'(i * 7), 12, 8);
        end
        sample_ready = 1'b0;
        check("wrap_fill", fill_level, 0);
        check("wrap_queue_empty", exp_q.size(), 0);

        // Framing errors: short and long frames.
        send_frame(16'h0155, 11, 8);
        send_frame(16'h1555, 13, 8);
        check("frame_err_set", frame_err, 1);
        check("frame_err_fill", fill_level, 0);
        clr_flags = 1'b1;
        wait_clk(1);
        clr_flags = 1'b0;
        check("frame_err_cleared", frame_err, 0);
        exp_q.push_back(12'h3C3);
        sample_ready = 1'b1;
        send_frame(16'h03C3, 12, 8);
        sample_ready = 1'b0;
        check("post_err_fill", fill_level, 0);
        check("post_err_queue_empty", exp_q.size(), 0);
        check("post_err_flag", frame_err, 0);

        // Reset in the middle of a frame (first 6 bits of 0x800).
        frame_bits(16'h0020, 6, 8);
        rst = 1'b1;
        wait_clk(2);
        check("midreset_outputs", {sample_valid, sample_data, fill_level, overflow, frame_err}, 0);
        SS = 1'b1;
        MOSI = 1'b0;
        wait_clk(2);
        rst = 1'b0;
        wait_clk(5);
        exp_q.push_back(12'h7FF);
        send_frame(16'h07FF, 12, 8);
        check("midreset_data", sample_data, 12'h7FF);
        check("midreset_fill", fill_level, 1);
        check("midreset_frame_err", frame_err, 0);
        sample_ready = 1'b1;
        wait_clk(1);
        sample_ready = 1'b0;

        // SCL activity with SS high must be ignored.
        for (int i = 0; i < 20; i++) begin
            MOSI = i[0];
            wait_clk(8);
            SCL = 1'b1;
            wait_clk(8);
            SCL = 1'b0;
        end
        wait_clk(10);
        check("noise_fill", fill_level, 0);
        check("noise_valid", sample_valid, 0);
        check("noise_flags", {overflow, frame_err}, 0);

        check("final_queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
